// File: rtl/arm_pkg.sv
// Shared flag-layout definitions for the status register block and its neighbours.
// Flags are held as {N,Z,C,V}, with N in the most significant bit.
package arm_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_AL = 4'd14;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/status_register_unit_if.sv
// Signal bundle between the pipeline and the status register unit.
// The master modport drives the pipeline side; the slave modport is the unit itself.
interface status_register_unit_if;
    import arm_pkg::*;

    logic   ex_valid;
    logic   ex_s_bit;
    flags_t ex_flags;
    logic   id_issue;
    logic   id_sets_flags;
    logic   id_cond_used;
    logic   freeze;
    logic   flush;
    logic   exc_entry;
    logic   exc_return;
    flags_t sr;
    flags_t spsr;
    logic   flag_hazard;

    modport master (
        output ex_valid, ex_s_bit, ex_flags, id_issue, id_sets_flags, id_cond_used,
        output freeze, flush, exc_entry, exc_return,
        input  sr, spsr, flag_hazard
    );

    modport slave (
        input  ex_valid, ex_s_bit, ex_flags, id_issue, id_sets_flags, id_cond_used,
        input  freeze, flush, exc_entry, exc_return,
        output sr, spsr, flag_hazard
    );

endinterface

// File: rtl/status_register_unit_flag_pending_tracker.sv
// Shift register of in-flight flag setters between ID and EX.
// Bit k set means a setter is k+1 stages past ID; the top bit is the EX stage.
module flag_pending_tracker #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             clear,
    input  logic             shift_in,
    output logic [DEPTH-1:0] pend
);

    logic [DEPTH-1:0] pend_reg;
    logic [DEPTH-1:0] pend_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign pend_next[gi] = shift_in;
            end else begin : g_tail
                assign pend_next[gi] = pend_reg[gi-1];
            end
        end
    endgenerate

    // A clear (flush or exception entry) wins over freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
        end else if (clear) begin
            pend_reg <= '0;
        end else if (!freeze) begin
            pend_reg <= pend_next;
        end
    end

    assign pend = pend_reg;

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV flags with SPSR shadow and flag-hazard detection for decode.
// Optional FLAG_FWD_EN: bypass EX flags straight to sr and stop stalling on the EX-stage writer.
module status_register_unit
    import arm_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    status_register_unit_if.slave bus
);

    logic   wr;
    logic   ret_eff;
    flags_t sr_reg;
    flags_t sr_next;
    flags_t spsr_reg;
    flags_t spsr_next;
    logic   shift_in;
    logic   hazard;
    logic [PIPE_DEPTH-1:0] pend;

`ifdef FLAG_FWD_EN
    // The EX-stage writer is covered by the bypass, so only younger setters stall.
    localparam logic [PIPE_DEPTH-1:0] HAZARD_MASK = {1'b0, {(PIPE_DEPTH-1){1'b1}}};
`else
    localparam logic [PIPE_DEPTH-1:0] HAZARD_MASK = {PIPE_DEPTH{1'b1}};
`endif

    assign wr      = bus.ex_valid & bus.ex_s_bit & ~bus.freeze;
    // Entry and return in the same cycle: the entry wins and the return is dropped.
    assign ret_eff = bus.exc_return & ~bus.exc_entry;

    always_comb begin
        sr_next = sr_reg;
        if (ret_eff) begin
            sr_next = spsr_reg;
        end else if (wr) begin
            sr_next = bus.ex_flags;
        end
    end

    always_comb begin
        spsr_next = spsr_reg;
        if (bus.exc_entry) begin
            spsr_next = wr ? bus.ex_flags : sr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg   <= '0;
            spsr_reg <= '0;
        end else begin
            sr_reg   <= sr_next;
            spsr_reg <= spsr_next;
        end
    end

    assign hazard   = bus.id_cond_used & (|(pend & HAZARD_MASK));
    assign shift_in = bus.id_issue & bus.id_sets_flags & ~hazard;

    flag_pending_tracker #(
        .DEPTH (PIPE_DEPTH)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze   (bus.freeze),
        .clear    (bus.flush | bus.exc_entry),
        .shift_in (shift_in),
        .pend     (pend)
    );

`ifdef FLAG_FWD_EN
    assign bus.sr = (wr & ~ret_eff) ? bus.ex_flags : sr_reg;
`else
    assign bus.sr = sr_reg;
`endif
    assign bus.spsr        = spsr_reg;
    assign bus.flag_hazard = hazard;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed bench for status_register_unit: expectations queued per step, then popped and checked.
// Build with or without FLAG_FWD_EN; the expectations follow the build.
module tb_status_register_unit;
    import arm_pkg::*;

    typedef struct {
        string      tag;
        int         sel;   // 0 = sr, 1 = spsr, 2 = flag_hazard
        logic [3:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    status_register_unit_if bus ();

    status_register_unit #(
        .PIPE_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FLAG_FWD_EN
    localparam logic HAZ_EX = 1'b0;   // hazard while only the EX-stage bit is pending
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic HAZ_EX = 1'b1;
    localparam logic FWD_ON = 1'b0;
`endif

    task automatic push(input string tag, input int sel, input logic [3:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = bus.sr;
                1:       obs = bus.spsr;
                default: obs = {3'b000, bus.flag_hazard};
            endcase
            n_total++;
            assert (obs === e.exp) begin
                n_pass++;
            end else begin
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
            $display("check %-14s observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    task automatic idle();
        bus.ex_valid      = 1'b0;
        bus.ex_s_bit      = 1'b0;
        bus.ex_flags      = 4'b0000;
        bus.id_issue      = 1'b0;
        bus.id_sets_flags = 1'b0;
        bus.id_cond_used  = 1'b0;
        bus.freeze        = 1'b0;
        bus.flush         = 1'b0;
        bus.exc_entry     = 1'b0;
        bus.exc_return    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [3:0] f);
        bus.ex_valid = 1'b1;
        bus.ex_s_bit = 1'b1;
        bus.ex_flags = f;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Load non-zero state, then reset in the middle of a cycle.
        commit(4'b1111);
        bus.exc_entry = 1'b1;
        step();
        idle();
        bus.id_issue      = 1'b1;
        bus.id_sets_flags = 1'b1;
        step();
        idle();
        bus.id_cond_used = 1'b1;
        #1;
        push("pre_rst_sr", 0, 4'b1111);
        push("pre_rst_spsr", 1, 4'b1111);
        push("pre_rst_haz", 2, 4'b0001);
        drain();
        #1 rst_n = 1'b0;
        #1;
        push("rst_sr", 0, 4'b0000);
        push("rst_spsr", 1, 4'b0000);
        push("rst_haz", 2, 4'b0000);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        // First commit after reset appears one cycle later.
        commit(4'b0100);
        step();
        idle();
        push("commit_0100", 0, 4'b0100);
        drain();

        // Hazard window behind a single setter; s_bit=0 write is ignored.
        bus.id_issue      = 1'b1;
        bus.id_sets_flags = 1'b1;
        step();
        idle();
        bus.id_cond_used = 1'b1;
        bus.ex_valid     = 1'b1;
        bus.ex_flags     = 4'b1111;
        #1;
        push("haz_c1", 2, 4'b0001);
        drain();
        step();
        push("haz_c2", 2, {3'b000, HAZ_EX});
        push("no_s_bit_sr", 0, 4'b0100);
        drain();
        step();
        push("haz_c3", 2, 4'b0000);
        drain();

        // Freeze holds the pending setter and blocks writes.
        idle();
        bus.id_issue      = 1'b1;
        bus.id_sets_flags = 1'b1;
        step();
        idle();
        bus.freeze       = 1'b1;
        bus.id_cond_used = 1'b1;
        commit(4'b1010);
        for (int i = 0; i < 3; i++) begin
            step();
            push($sformatf("frz_haz_%0d", i), 2, 4'b0001);
            push($sformatf("frz_sr_%0d", i), 0, 4'b0100);
            drain();
        end
        idle();
        bus.id_cond_used = 1'b1;
        step();
        push("unfrz_haz", 2, {3'b000, HAZ_EX});
        drain();
        step();
        push("unfrz_clear", 2, 4'b0000);
        drain();

        // Two setters pending, then flush (with freeze) clears everything.
        idle();
        bus.id_issue      = 1'b1;
        bus.id_sets_flags = 1'b1;
        step();
        step();
        idle();
        bus.id_cond_used = 1'b1;
        #1;
        push("pend11_haz", 2, 4'b0001);
        drain();
        bus.flush  = 1'b1;
        bus.freeze = 1'b1;
        step();
        bus.flush  = 1'b0;
        bus.freeze = 1'b0;
        #1;
        push("flush_haz", 2, 4'b0000);
        drain();

        // Exception entry saves the post-commit value; return restores it.
        idle();
        commit(4'b1001);
        step();
        push("sr_1001", 0, 4'b1001);
        drain();
        commit(4'b0010);
        bus.exc_entry = 1'b1;
        step();
        idle();
        push("entry_spsr", 1, 4'b0010);
        push("entry_sr", 0, 4'b0010);
        drain();
        commit(4'b1111);
        step();
        idle();
        push("sr_1111", 0, 4'b1111);
        drain();
        bus.exc_return = 1'b1;
        bus.freeze     = 1'b1;
        step();
        idle();
        push("return_sr", 0, 4'b0010);
        drain();
        commit(4'b0101);
        step();
        idle();
        bus.exc_entry  = 1'b1;
        bus.exc_return = 1'b1;
        step();
        idle();
        push("both_spsr", 1, 4'b0101);
        push("both_sr", 0, 4'b0101);
        drain();

        // Same-cycle visibility depends on the bypass.
        commit(4'b1000);
        #1;
        push("fwd_same", 0, FWD_ON ? 4'b1000 : 4'b0101);
        drain();
        step();
        idle();
        push("fwd_next", 0, 4'b1000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
- Holds the architectural NZCV flags and drives the 4-bit SR input of the condition-check stage directly downstream.
- Commits flags from the execute stage when an instruction's S bit is set.
- Saves and restores the flags through a shadow copy (SPSR) on exception entry and return.
- Tracks in-flight flag-setting instructions and raises a hazard so decode stalls a conditional instruction until its flags are final.

Parameters:
- PIPE_DEPTH, 2, number of stages from ID issue to flag commit in EX; legal range 2..8.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a valid, non-squashed instruction
- ex_s_bit  in  1  EX instruction updates flags (S bit)
- ex_flags  in  4  {N,Z,C,V} produced by the ALU this cycle
- id_issue  in  1  decode advances an instruction into ID/EX this cycle
- id_sets_flags  in  1  the issuing instruction has its S bit set
- id_cond_used  in  1  the decode instruction's condition field is not 4'd14 (AL)
- freeze  in  1  pipeline stall; holds all state
- flush  in  1  branch-taken squash of all younger instructions
- exc_entry  in  1  single-cycle exception-entry pulse
- exc_return  in  1  single-cycle exception-return pulse
- sr  out  4  {N,Z,C,V} to the condition-check stage
- spsr  out  4  saved flags
- flag_hazard  out  1  decode must stall

Behaviour:
- Reset (async, rst_n=0): SR=0, SPSR=0, pend=0. As a result, sr=0, spsr=0 and flag_hazard=0 immediately, not waiting for a clock edge.
- Define wr = ex_valid & ex_s_bit & !freeze.
- SR update on the rising edge, in priority order:
  1. exc_return: SR <= SPSR.
  2. wr: SR <= ex_flags.
  3. Otherwise SR holds.
- SPSR update on the rising edge:
  - On exc_entry: SPSR <= (wr ? ex_flags : SR), i.e. the entry saves the post-commit value.
  - Otherwise SPSR holds.
- exc_entry and exc_return asserted together: entry wins and the return is ignored.
- exc_entry/exc_return are honoured even when freeze=1.
- Pending tracker pend[PIPE_DEPTH-1:0]:
  - Bit k set means a flag setter is k+1 stages past ID.
  - Bit PIPE_DEPTH-1 is the EX stage.
- Each non-frozen edge: pend <= {pend[PIPE_DEPTH-2:0], id_issue & id_sets_flags & !flag_hazard}.
- freeze=1: pend holds.
- flush=1: pend <= 0. Flush overrides freeze and the shift-in.
- exc_entry also clears pend.
- flag_hazard (combinational) = id_cond_used & (|pend).
  - A flag-setting instruction that is itself conditional also stalls on older setters.
- sr = SR register output; latency from an EX commit to sr is 1 cycle.
- Boundaries:
  - Back-to-back flag setters: each commit overwrites SR in order.
  - A hazard clears the cycle after the last pend bit shifts out.
  - Reset mid-stall: pend cleared and hazard drops asynchronously.
  - wr with ex_s_bit=0: SR unchanged.

Optional Feature:
- Macro FLAG_FWD_EN.
- Defined:
  - sr = wr ? ex_flags : SR, a combinational bypass.
  - flag_hazard = id_cond_used & (|pend[PIPE_DEPTH-2:0]), so the EX-stage writer no longer stalls decode.
  - On exc_return, sr shows SR (the bypass is suppressed).
- Undefined: behaviour exactly as above, with no bypass path.

Decomposition:
- Shared package arm_pkg:
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Condition code constant COND_AL=4'd14.
  - Typedef flags_t (4-bit).
- One natural sub-module, flag_pending_tracker: the pend shift register with freeze/flush, exposing the pend vector.

Test Plan:
- Reset: rst_n=0 mid-cycle -> sr=0, spsr=0, flag_hazard=0 immediately; rst_n=1 then ex_valid=1, ex_s_bit=1, ex_flags=4'b0100 -> sr=4'b0100 next cycle.
- Hazard: id_issue=1, id_sets_flags=1, then id_cond_used=1 -> flag_hazard=1 for 2 cycles with PIPE_DEPTH=2, and for 1 cycle with FLAG_FWD_EN.
- Freeze: setter in pend[0], freeze=1 for 3 cycles -> pend frozen, hazard stays 1; an ex_flags write is ignored.
- Flush: pend=2'b11, flush=1 -> pend=0 and flag_hazard=0 the next cycle.
- Exception: SR=4'b1001, exc_entry together with a commit of 4'b0010 -> SPSR=4'b0010; later SR=4'b1111, exc_return -> sr=4'b0010; exc_entry+exc_return together -> SPSR updated, SR not restored.
- Forwarding (FLAG_FWD_EN): wr with ex_flags=4'b1000 -> sr=4'b1000 in the same cycle; without the macro sr=4'b1000 one cycle later.
